md_unit_iter: RTL and testbench
===============================

Name: md_unit_iter

Overview:
- Parametrised successor to the pipeline's multiply/divide unit. Owns the HI/LO architectural registers.
- Executes mult/multu/div/divu, mthi/mtlo, and the new accumulate ops madd/maddu/msub/msubu.
- Division is a genuine iterative radix-2 restoring divider; there is no behavioural "/" or "%".
- Sits in the E stage. Exposes `occupy` for the hazard unit and supports a `flush` abort for exception/interrupt entry.

Parameters:
- WIDTH, 32, operand and HI/LO width (even, >= 8).
- MUL_LAT, 5, cycles busy after a multiply or accumulate start (>= 1).
- RST_HILO, 0, reset value loaded into HI and LO.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- start  in  1  E-stage op valid this cycle.
- op  in  4  operation code (md_pkg encodings).
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- flush  in  1  abort in-flight op; drop this cycle's start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  registered; an operation is in flight.
- occupy  out  1  combinational: `busy | (start & op is a long op)`. The hazard unit stalls mfhi/mflo/md ops on it.
- done  out  1  one-cycle pulse in the cycle after HI/LO are written by a long op.

Behaviour:
- Reset state: hi=lo=RST_HILO; busy=0; done=0; internal counter, state and scratch all 0. Reset mid-operation abandons the op.
- Acceptance: start is acted on only when busy=0 and flush=0. A start while busy=1 is ignored; upstream must stall on occupy.
- Short ops (mthi/mtlo): write hi (resp. lo) = a at the sampling edge. busy stays 0; no done pulse.
- Long ops and the FSM: states IDLE, MUL, DIV, FIX.
- MUL (mult/multu/madd/maddu/msub/msubu):
  - At acceptance, latch the 2*WIDTH product (signed or unsigned per op) and an accumulate/subtract flag. busy=1.
  - Counter runs 1..MUL_LAT. On the edge ending count MUL_LAT:
    - mult/multu: {hi,lo} = P.
    - madd/maddu: {hi,lo} = {hi,lo} + P.
    - msub/msubu: {hi,lo} = {hi,lo} - P.
    - Accumulate uses HI/LO as they are at completion, arithmetic mod 2^(2*WIDTH).
  - On that same edge busy returns to 0 and done pulses next cycle. busy is high for exactly MUL_LAT cycles.
- DIV (div/divu):
  - At acceptance, latch |a| and |b| for signed ops, else raw a and b, plus the signs.
  - WIDTH iterations, one quotient bit per cycle, restoring step on a (WIDTH+1)-bit remainder.
  - Then one FIX cycle applies signs: quotient negated if the signs differ; remainder takes the sign of a.
  - FIX writes lo=quotient, hi=remainder. busy is high for WIDTH+1 cycles (33 at default).
- Division edge cases, both still taking the full WIDTH+1 cycles:
  - b=0 gives lo = all ones, hi = a.
  - Signed MIN / -1 gives lo = MIN, hi = 0.
- flush:
  - With busy=1: at the edge, return to IDLE and clear busy. hi/lo are left unchanged, no done pulse.
  - flush together with start: the start is dropped.
  - flush on the completing edge: the write is suppressed.
- mthi/mtlo while busy=1 are ignored.
- Undefined op codes with start=1 are treated as no-op.

Decomposition:
- md_pkg holds:
  - op encodings: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU;
  - FSM state enum;
  - the is_long_op function used by occupy.
- One sub-module: md_div_iter.
  - Restoring divider: start, a, b, signed, plus flush.
  - Returns q, r and a valid pulse, with the zero-divisor and overflow handling inside it.
- The top level keeps HI/LO, the multiply/accumulate path and the FSM.

Test Plan:
- mult a=0xFFFFFFFE, b=3 at WIDTH=32, MUL_LAT=5 -> busy high 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA; then maddu a=1, b=6 -> hi=0x00000003, lo=0x00000000 (carry into HI).
- div a=-7, b=2 -> busy exactly 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; a second start issued while busy is ignored and occupy=1 throughout.
- Preload hi=0x1234 via mthi; start div, assert flush at cycle 10 -> busy=0 next cycle, hi still 0x1234, no done; repeat with flush on the completing edge -> no HI/LO write.
- Reset asserted mid-multiply at cycle 3 -> hi=lo=RST_HILO and busy=0 after the edge; an mtlo a=0x55 on the next cycle -> lo=0x55 and busy stays 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_t        : 4-bit operation codes presented on md_unit_iter.op
//   md_state_t  : top-level FSM states (IDLE, MUL, DIV, FIX)
//   acc_mode_t  : how a finished product is folded into {hi,lo}
//   is_long_op  : true for ops that occupy the unit for several cycles
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    typedef enum logic [1:0] {
        ACC_SET = 2'd0,
        ACC_ADD = 2'd1,
        ACC_SUB = 2'd2
    } acc_mode_t;

    function automatic logic is_long_op(input logic [3:0] op);
        logic res;
        case (op_t'(op))
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: res = 1'b1;
            default:                              res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Radix-2 restoring divider, one quotient bit per clock.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a division (caller guarantees the unit is free)
//   a, b        : dividend, divisor
//   is_signed   : treat a/b as two's complement
//   flush       : abandon the division in progress
//   q, r        : sign-corrected quotient / remainder, meaningful while valid=1
//   valid       : high for the single fix-up cycle after the WIDTH-th step
// Timing: start edge latches operands, the next WIDTH edges each retire one
// quotient bit, then valid is high for one cycle with the final q/r.
module md_div_iter
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             flush,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic          run;
    logic          fix;
    logic [CW-1:0] dcnt;
    logic [WIDTH:0]   rem;   // partial remainder, one guard bit
    logic [WIDTH-1:0] dvd;   // dividend bits shift out the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dsr;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic             ovf;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] diff;
    logic             qbit;
    logic [WIDTH:0]   rem_nxt;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // Trial subtraction of the divisor from {rem, next dividend bit};
    // a borrow out of the top means the bit is 0 and the old value is kept.
    assign diff    = {rem, dvd[WIDTH-1]} - {2'b00, dsr};
    assign qbit    = ~diff[WIDTH+1];
    assign rem_nxt = qbit ? diff[WIDTH:0] : {rem[WIDTH-1:0], dvd[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            run   <= 1'b0;
            fix   <= 1'b0;
            dcnt  <= '0;
            rem   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            ovf   <= 1'b0;
        end else if (flush) begin
            run  <= 1'b0;
            fix  <= 1'b0;
            dcnt <= '0;
        end else if (start) begin
            run   <= 1'b1;
            fix   <= 1'b0;
            dcnt  <= '0;
            rem   <= '0;
            dvd   <= a_mag;
            dsr   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            div0  <= (b == '0);
            ovf   <= is_signed & (a == MIN_VAL) & (b == '1);
        end else if (run) begin
            rem  <= rem_nxt;
            dvd  <= {dvd[WIDTH-2:0], qbit};
            dcnt <= dcnt + CW'(1);
            if (dcnt == CW'(WIDTH-1)) begin
                run <= 1'b0;
                fix <= 1'b1;
            end
        end else begin
            fix <= 1'b0;
        end
    end

    // Fix-up: a zero divisor yields all-ones / dividend (the magnitude path
    // already leaves |a| in rem, and re-applying a's sign restores a);
    // MIN / -1 is pinned to MIN remainder 0 rather than relying on wrap.
    always_comb begin
        q = neg_q ? (~dvd + 1'b1) : dvd;
        r = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
        if (div0) begin
            q = '1;
        end else if (ovf) begin
            q = MIN_VAL;
            r = '0;
        end
    end

    assign valid = fix;

endmodule

// File: rtl/md_unit_iter.sv
// Multiply/divide unit for the E stage; owns the HI/LO registers.
//   clk, reset   : clock, synchronous active-high reset
//   start, op    : operation request and its md_pkg op code
//   a, b         : rs / rt operands
//   flush        : abort any in-flight op and drop this cycle's start
//   hi, lo       : architectural HI / LO
//   busy         : registered, a long op is in flight
//   occupy       : busy, or a long op being requested this cycle
//   done         : one-cycle pulse the cycle after a long op writes HI/LO
// Handshake: a request is taken on the edge where start=1, busy=0 and
// flush=0; requests seen while busy=1 are silently dropped, so the issuing
// stage must hold off while occupy=1. Long ops report completion only through
// done; mthi/mtlo complete on the accepting edge and never raise busy/done.
module md_unit_iter
    import md_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               MUL_LAT  = 5,
    parameter logic [WIDTH-1:0] RST_HILO = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             occupy,
    output logic             done
);

    localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    md_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2*WIDTH-1:0] prod;
    acc_mode_t acc, acc_sel;

    op_t  op_e;
    logic accept;
    logic mul_signed;
    logic div_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod_now, mul_res;

    logic mul_go, div_go, mt_hi, mt_lo, fin_mul, fin_div, done_nxt;
    logic [WIDTH-1:0] div_q, div_r;
    logic             div_valid;

    assign op_e   = op_t'(op);
    assign busy   = (state != ST_IDLE);
    assign occupy = busy | (start & is_long_op(op));
    assign accept = start & ~busy & ~flush;

    assign mul_signed = (op_e == OP_MULT) || (op_e == OP_MADD) || (op_e == OP_MSUB);
    assign div_signed = (op_e == OP_DIV);

    // Sign- or zero-extend to 2*WIDTH so one multiplier serves both flavours;
    // the low 2*WIDTH bits of the extended product are exact either way.
    assign a_ext    = {{WIDTH{mul_signed & a[WIDTH-1]}}, a};
    assign b_ext    = {{WIDTH{mul_signed & b[WIDTH-1]}}, b};
    assign prod_now = a_ext * b_ext;

    always_comb begin
        case (op_e)
            OP_MADD, OP_MADDU: acc_sel = ACC_ADD;
            OP_MSUB, OP_MSUBU: acc_sel = ACC_SUB;
            default:           acc_sel = ACC_SET;
        endcase
    end

    // Accumulation reads HI/LO at completion, not at issue.
    always_comb begin
        case (acc)
            ACC_ADD: mul_res = {hi, lo} + prod;
            ACC_SUB: mul_res = {hi, lo} - prod;
            default: mul_res = prod;
        endcase
    end

    md_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_go),
        .a         (a),
        .b         (b),
        .is_signed (div_signed),
        .flush     (flush),
        .q         (div_q),
        .r         (div_r),
        .valid     (div_valid)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mul_go    = 1'b0;
        div_go    = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        fin_mul   = 1'b0;
        fin_div   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op_e)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            state_nxt = ST_MUL;
                            cnt_nxt   = CW'(1);
                            mul_go    = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nxt = ST_DIV;
                            cnt_nxt   = CW'(1);
                            div_go    = 1'b1;
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(MUL_LAT)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    fin_mul   = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(WIDTH)) begin
                    state_nxt = ST_FIX;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_FIX: begin
                state_nxt = ST_IDLE;
                if (!flush && div_valid) begin
                    fin_div  = 1'b1;
                    done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= RST_HILO;
            lo    <= RST_HILO;
            state <= ST_IDLE;
            cnt   <= '0;
            prod  <= '0;
            acc   <= ACC_SET;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            if (mul_go) begin
                prod <= prod_now;
                acc  <= acc_sel;
            end
            if (fin_mul) begin
                {hi, lo} <= mul_res;
            end else if (fin_div) begin
                hi <= div_r;
                lo <= div_q;
            end else begin
                if (mt_hi) hi <= a;
                if (mt_lo) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit_iter.sv
// Bench for md_unit_iter: directed scenarios plus random ops, with a
// reference model kept as plain 64-bit arithmetic and a done-driven monitor.
module tb_md_unit_iter;
  import md_pkg::*;

  localparam int          W   = 32;
  localparam int          ML  = 5;
  localparam logic [31:0] RST = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, occupy, done;

  md_unit_iter #(.WIDTH(W), .MUL_LAT(ML), .RST_HILO(RST)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .occupy(occupy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] h,
                                         input logic [31:0] l);
    longint      sx, sy, ux, uy;
    logic [63:0] hl, res;
    logic [31:0] qv, rv;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    hl = {h, l};
    res = hl;
    case (o)
      OP_MULT:  res = sx * sy;
      OP_MULTU: res = ux * uy;
      OP_MADD:  res = hl + 64'(sx * sy);
      OP_MADDU: res = hl + 64'(ux * uy);
      OP_MSUB:  res = hl - 64'(sx * sy);
      OP_MSUBU: res = hl - 64'(ux * uy);
      OP_DIV: begin
        if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          qv = $signed(x) / $signed(y);
          rv = $signed(x) % $signed(y);
          res = {rv, qv};
        end
      end
      OP_DIVU: begin
        if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      OP_MTHI: res = {x, l};
      OP_MTLO: res = {h, x};
      default: res = hl;
    endcase
    return res;
  endfunction

  function automatic int busy_len(input logic [3:0] o);
    if (o inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU}) return ML;
    if (o inside {OP_DIV, OP_DIVU}) return W + 1;
    return 0;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual hi=%h lo=%h expected no done pulse", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_hilo", {hi, lo}, mon_e);
      end
    end
  end

  // driver: issue one op, measure busy length, update model
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int          n, ec;
    logic [63:0] nv;
    ec = busy_len(o);
    nv = ref_op(o, x, y, m_hi, m_lo);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 check("occupy_at_issue", {63'b0, occupy}, {63'b0, ec != 0});
    if (ec != 0) exp_q.push_back(nv);
    {m_hi, m_lo} = nv;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'(ec));
    if (ec == 0) check("short_hilo", {hi, lo}, nv);
  endtask

  // drive a long op that will be aborted; returns after the issuing edge
  task automatic issue_raw(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n, occ_bad;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", {32'h0, hi}, {32'h0, RST});
    check("reset_lo", {32'h0, lo}, {32'h0, RST});
    check("reset_busy", {63'b0, busy}, 64'h0);
    check("reset_done", {63'b0, done}, 64'h0);
    check("reset_occupy", {63'b0, occupy}, 64'h0);
    reset = 1'b0;
    m_hi = RST; m_lo = RST;

    // signed / unsigned multiply and accumulate carry
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    check("multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    run_op(OP_MADDU, 32'd1, 32'd6);
    check("maddu_carry", {hi, lo}, 64'h0000_0003_0000_0000);

    // division and divide by zero
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd7, 32'd0);
    check("divu_by0", {hi, lo}, 64'h0000_0007_FFFF_FFFF);

    // MIN / -1 with an extra start while busy
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
    exp_q.push_back(64'h0000_0000_8000_0000);
    m_hi = 32'h0; m_lo = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    n = 0; occ_bad = 0;
    while (busy && n < 200) begin
      n++;
      if (!occupy) occ_bad++;
      if (n == 5) begin start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3; end
      else start = 1'b0;
      @(negedge clk);
    end
    check("ovf_busy_cycles", 64'(n), 64'(W + 1));
    check("ovf_occupy_low", 64'(occ_bad), 64'h0);
    check("ovf_result", {hi, lo}, 64'h0000_0000_8000_0000);
    repeat (3) @(negedge clk);
    check("ignored_start_idle", {63'b0, busy}, 64'h0);

    // flush mid-division
    run_op(OP_MTHI, 32'h0000_1234, 32'h0);
    issue_raw(OP_DIV, 32'd1000, 32'd7);
    n = 1;
    while (busy && n < 10) begin n++; @(negedge clk); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'h0);
    check("flush_hilo", {hi, lo}, {32'h0000_1234, m_lo});
    repeat (3) @(negedge clk);

    // flush on the completing edge
    issue_raw(OP_DIV, 32'd100, 32'd7);
    n = 1;
    while (busy && n < W + 1) begin n++; @(negedge clk); end
    check("flush_last_cycle_busy", {63'b0, busy}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_last_busy", {63'b0, busy}, 64'h0);
    check("flush_last_done", {63'b0, done}, 64'h0);
    check("flush_last_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (2) @(negedge clk);

    // flush together with start drops the start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'b0, busy}, 64'h0);
    repeat (ML + 2) @(negedge clk);
    check("flush_start_hilo", {hi, lo}, {m_hi, m_lo});

    // reset in the middle of a multiply
    issue_raw(OP_MULT, 32'd5, 32'd7);
    n = 1;
    while (busy && n < 3) begin n++; @(negedge clk); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_hilo", {hi, lo}, {RST, RST});
    check("midreset_busy", {63'b0, busy}, 64'h0);
    m_hi = RST; m_lo = RST;
    run_op(OP_MTLO, 32'h55, 32'h0);
    check("mtlo_after_reset", {32'h0, lo}, 64'h55);

    // random ops against the model
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
